// File: rtl/baseline.sv
// Matrix-vector dot-product pipeline: a 16-word vector register file feeds
// NUM_LDPES dot-product lanes against a constant weight table (lane l
// weight = l+1). Three stages: VRF read, per-lane dot product, accumulate.
// A done strobe folds any in-flight dot into the result and clears the
// accumulators in the same edge.
module baseline #(
    parameter int ELEM_W     = 8,
    parameter int LANE_ELEMS = 8,
    parameter int VRF_AWIDTH = 4,
    parameter int VRF_DWIDTH = ELEM_W * LANE_ELEMS,
    parameter int NUM_LDPES  = 4,
    parameter int ACC_W      = 32,
    parameter int ORF_DWIDTH = NUM_LDPES * ACC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  done,
    input  logic                  vec_we,
    input  logic [VRF_AWIDTH-1:0] vrf_wr_addr,
    input  logic [VRF_DWIDTH-1:0] vec,
    output logic [ORF_DWIDTH-1:0] result
);

    localparam int VRF_DEPTH = 1 << VRF_AWIDTH;

    logic [VRF_DWIDTH-1:0] r_vrf [VRF_DEPTH];
    logic [VRF_AWIDTH-1:0] r_rd_ptr;
    logic [VRF_DWIDTH-1:0] r_rd_data;
    logic                  r_v1;
    logic                  r_v2;
    logic [ACC_W-1:0]      r_dot [NUM_LDPES];
    logic [ACC_W-1:0]      r_acc [NUM_LDPES];
    logic [ORF_DWIDTH-1:0] r_result;

    logic [ACC_W-1:0]      w_dot [NUM_LDPES];
    logic [ACC_W-1:0]      w_sum [NUM_LDPES];

    assign result = r_result;

    // Constant weight table: every element of lane l uses weight l+1.
    function automatic logic [ACC_W-1:0] mrf_weight(input int unsigned lane);
        return ACC_W'(lane + 1);
    endfunction

    function automatic logic [ACC_W-1:0] sext_elem(input logic [ELEM_W-1:0] e);
        return {{(ACC_W - ELEM_W){e[ELEM_W-1]}}, e};
    endfunction

    // VRF write port; independent of reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (vec_we) begin
            r_vrf[vrf_wr_addr] <= vec;
        end
    end

    // Stage 1: read the word at the read pointer while start is high.
    // A write to the same address on the same edge is not visible here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
            r_v1      <= 1'b0;
        end else if (start) begin
            r_rd_data <= r_vrf[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_v1      <= 1'b1;
        end else begin
            r_v1      <= 1'b0;
        end
    end

    // Per-lane signed dot product of the read word against the lane weight.
    always_comb begin
        for (int unsigned l = 0; l < NUM_LDPES; l++) begin
            w_dot[l] = '0;
            for (int unsigned e = 0; e < LANE_ELEMS; e++) begin
                w_dot[l] = w_dot[l]
                         + sext_elem(r_rd_data[e*ELEM_W +: ELEM_W]) * mrf_weight(l);
            end
        end
    end

    // Stage 2: register the dot products and their valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2 <= 1'b0;
            for (int unsigned l = 0; l < NUM_LDPES; l++) begin
                r_dot[l] <= '0;
            end
        end else begin
            r_v2 <= r_v1;
            for (int unsigned l = 0; l < NUM_LDPES; l++) begin
                r_dot[l] <= w_dot[l];
            end
        end
    end

    // Accumulator plus the in-flight dot; shared by accumulate and flush.
    always_comb begin
        for (int unsigned l = 0; l < NUM_LDPES; l++) begin
            w_sum[l] = r_acc[l] + (r_v2 ? r_dot[l] : '0);
        end
    end

    // Stage 3: accumulate, or on done publish the sum and clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            for (int unsigned l = 0; l < NUM_LDPES; l++) begin
                r_acc[l] <= '0;
            end
        end else begin
            for (int unsigned l = 0; l < NUM_LDPES; l++) begin
                if (done) begin
                    r_result[l*ACC_W +: ACC_W] <= w_sum[l];
                    r_acc[l]                   <= '0;
                end else begin
                    r_acc[l]                   <= w_sum[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_baseline.sv
// Bench for baseline: a behavioural pipeline model pushes expected results
// to a queue at every done edge; they are popped and compared after the
// edge. Table vectors additionally pin known closed-form results.
module tb_baseline;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         done = 1'b0;
    logic         vec_we = 1'b0;
    logic [3:0]   vrf_wr_addr = '0;
    logic [63:0]  vec = '0;
    logic [127:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    baseline #(
        .ELEM_W(8),
        .LANE_ELEMS(8),
        .VRF_AWIDTH(4),
        .NUM_LDPES(4),
        .ACC_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .done(done),
        .vec_we(vec_we),
        .vrf_wr_addr(vrf_wr_addr),
        .vec(vec),
        .result(result)
    );

    // Reference model state
    logic [63:0]  m_mem [16];
    logic [3:0]   m_ptr = '0;
    logic [127:0] m_acc = '0;
    logic [127:0] m_d1 = '0;
    logic [127:0] m_d2 = '0;
    logic         m_v1 = 1'b0;
    logic         m_v2 = 1'b0;
    logic [127:0] m_result = '0;
    logic [127:0] exp_q [$];

    typedef struct {
        int           pat;
        int           nstart;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [4];

    function automatic logic [127:0] lanes4(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    // Sum the signed elements once, then scale by each lane's weight.
    function automatic logic [127:0] model_dot(input logic [63:0] w);
        int s;
        logic [127:0] r;
        s = 0;
        for (int e = 0; e < 8; e++) begin
            s += int'($signed(w[e*8 +: 8]));
        end
        for (int l = 0; l < 4; l++) begin
            r[l*32 +: 32] = 32'(s * (l + 1));
        end
        return r;
    endfunction

    function automatic logic [127:0] lane_add(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        for (int l = 0; l < 4; l++) begin
            r[l*32 +: 32] = a[l*32 +: 32] + b[l*32 +: 32];
        end
        return r;
    endfunction

    function automatic logic [63:0] pattern(input int pat, input int a);
        logic [7:0] b;
        b = 8'(a);
        case (pat)
            0:       return 64'h0101_0101_0101_0101;
            1:       return '1;
            default: return {8{b}};
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance the model with the current inputs, clock the DUT, then score.
    task automatic tick();
        logic [127:0] sum;
        logic         chk;
        chk = done && !rst;
        if (rst) begin
            m_ptr = '0; m_acc = '0; m_d1 = '0; m_d2 = '0;
            m_v1 = 1'b0; m_v2 = 1'b0; m_result = '0;
        end else begin
            sum = m_v2 ? lane_add(m_acc, m_d2) : m_acc;
            if (done) begin
                m_result = sum;
                exp_q.push_back(sum);
                m_acc = '0;
            end else begin
                m_acc = sum;
            end
            m_d2 = m_d1;
            m_v2 = m_v1;
            if (start) begin
                m_d1 = model_dot(m_mem[m_ptr]);
                m_v1 = 1'b1;
                m_ptr = m_ptr + 4'd1;
            end else begin
                m_v1 = 1'b0;
            end
        end
        if (vec_we) m_mem[vrf_wr_addr] = vec;
        @(posedge clk);
        #1;
        if (chk) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: got no entry expected one");
            end else begin
                check("sb_flush", result, exp_q.pop_front());
            end
        end
    endtask

    task automatic write_all(input int pat);
        for (int a = 0; a < 16; a++) begin
            vec_we = 1'b1;
            vrf_wr_addr = 4'(a);
            vec = pattern(pat, a);
            tick();
        end
        vec_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic burst_and_flush(input int nstart);
        start = 1'b1;
        repeat (nstart) tick();
        start = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0, 10, lanes4(80, 160, 240, 320)};
        tbl[1] = '{1, 10, lanes4(-80, -160, -240, -320)};
        tbl[2] = '{2, 17, lanes4(960, 1920, 2880, 3840)};
        tbl[3] = '{2, 7, lanes4(168, 336, 504, 672)};

        // Reset state, and done pulses with no data keep result at zero
        do_reset();
        check("reset", result, '0);
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        check("idle_done", result, '0);

        // Table vectors
        for (int i = 0; i < 4; i++) begin
            write_all(tbl[i].pat);
            do_reset();
            burst_and_flush(tbl[i].nstart);
            check("vec_tbl", result, tbl[i].exp);
            repeat (3) tick();
            check("vec_hold", result, m_result);
        end
        check("lane0_neg", {96'd0, tbl[1].exp[31:0]}, {96'd0, 32'hFFFF_FFB0});

        // Reset after a nonzero result clears it
        do_reset();
        check("reset_clear", result, '0);

        // Repeated flush with start held
        write_all(0);
        do_reset();
        start = 1'b1;
        for (int c = 0; c < 45; c++) begin
            done = (c % 11 == 10);
            tick();
            if (c > 10 && (c % 11 == 10)) check("flush_tbl", result, lanes4(88, 176, 264, 352));
        end
        start = 1'b0;
        done = 1'b0;
        repeat (2) tick();

        // Reset mid-run discards in-flight work and restarts at address 0
        write_all(0);
        do_reset();
        start = 1'b1;
        repeat (5) tick();
        start = 1'b0;
        do_reset();
        burst_and_flush(3);
        check("midrst", result, lanes4(24, 48, 72, 96));

        // Read/write collision returns the old word; later reads see the new one
        write_all(2);
        do_reset();
        start = 1'b1;
        vec_we = 1'b1;
        vrf_wr_addr = 4'd0;
        vec = 64'h0202_0202_0202_0202;
        tick();
        start = 1'b0;
        vec_we = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("collide_old", result, '0);
        do_reset();
        burst_and_flush(1);
        check("collide_new", result, lanes4(16, 32, 48, 64));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
